pipe_trace_tx: RTL and testbench
================================

# pipe_trace_tx

Per-cycle pipeline trace transmitter for the 5-stage MIPS CPU. It samples the PC, hazard-unit stall, IF/ID flush and register-file writeback every active cycle. It packs each sample into a 3-word record, buffers records in a small FIFO, and streams them out over a valid/ready word interface to an external trace sink. It also keeps running stall, flush and drop totals, so that cycle accounting is produced in hardware instead of by a bench-side monitor.

## Interface
Parameters:
- DEPTH, 4, FIFO capacity in records; power of two, at least 2
- CNT_W, 16, width of the stall, flush and drop counters

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  trace enable; capture occurs only while high
- pc_i  in  32  current PC register value
- stall_i  in  1  hazard unit holding IF/ID this cycle
- flush_i  in  1  IF/ID flush this cycle
- wb_en_i  in  1  register-file write this cycle
- wb_addr_i  in  5  writeback register address
- wb_data_i  in  32  writeback data
- trace_data_o  out  32  current stream word
- trace_valid_o  out  1  trace_data_o is valid
- trace_ready_i  in  1  sink accepts the word
- trace_last_o  out  1  current word is the last word of a record
- stall_cnt_o  out  CNT_W  total stall cycles, saturating
- flush_cnt_o  out  CNT_W  total flush cycles, saturating
- drop_cnt_o  out  CNT_W  total records dropped, saturating

## Operation
- **Cycle counter:** 22 bits. Increments on every edge with start_i=1 and wraps from 0x3FFFFF to 0. It holds while start_i=0.
- **Capture:**
  - A capture happens on an edge where start_i=1 and the capture condition holds (see Configuration).
  - The record holds the input values at that edge and the cycle counter value before its increment.
- **Record format:**
  - W0: [31]=1, [30]=ovf, [29]=stall_i, [28]=flush_i, [27]=wb_en_i, [26:22]=wb_addr_i, [21:0]=cycle.
  - W1: pc_i.
  - W2: wb_data_i when wb_en_i=1, otherwise 0.
- **Overflow:**
  - A capture that finds the FIFO full is dropped, drop_cnt_o increments and the ovf flag is set.
  - The next accepted record carries ovf=1 in W0, and the flag clears.
  - Fullness is evaluated before any pop on the same edge. A capture on the edge where the last word of a full FIFO is accepted is still dropped.
- **Event counters:**
  - stall_cnt_o increments on edges with start_i & stall_i.
  - flush_cnt_o increments on edges with start_i & flush_i.
  - Both count independently of capture or drop.
  - All three counters saturate at all-ones.
- **Serializer:**
  - A word index cycles 0 → 1 → 2 and selects W0, W1 or W2 of the FIFO head.
  - trace_valid_o = FIFO not empty.
  - A handshake occurs when valid & ready are both high on an edge.
  - The index advances on each handshake.
  - A handshake on index 2 pops the head and resets the index to 0.
  - trace_last_o = valid & (index==2).
  - When the FIFO is empty, trace_data_o=0.
- **start_i low:** no capture takes place, but the serializer keeps draining buffered records.

## Timing
- Reset values: trace_valid_o=0, trace_last_o=0, trace_data_o=0. All counters, the ovf flag, the word index and the FIFO pointers are 0.
- Reset asserted mid-record discards the FIFO contents and the partial record. Valid is low from the first edge with rst_i=1. The cycle counter restarts at 0.
- Capture latency: for a record captured at edge E, W0 is valid in the cycle after E, provided the FIFO was empty.
- Throughput: one word per cycle while ready=1. Consecutive records stream without a bubble.
- While valid=1 and ready=0, trace_data_o and trace_last_o hold stable. Valid never drops without a handshake, except on reset.
- A simultaneous push and pop on the same edge is allowed when the FIFO is not full; count stays unchanged.

## Configuration
- TRACE_EVENT_ONLY_EN defined:
  - The capture condition is stall_i | flush_i | wb_en_i.
  - Idle cycles produce no record, but the cycle counter still advances, so W0 timestamps show the gaps.
- TRACE_EVENT_ONLY_EN undefined:
  - Every cycle with start_i=1 is captured.

## Test plan
- **Single record:** reset, then start_i=1 for one edge with pc_i=0x8, wb_en_i=1, wb_addr_i=9, wb_data_i=5, ready=1.
  - Stream W0=0x8A400000, W1=0x8, W2=0x5, with last on W2.
- **Backpressure:** hold ready=0 for 10 cycles during W1.
  - trace_data_o stays 0x8 and valid stays 1.
  - The stream resumes with W2 after ready rises.
- **Overflow:** ready=0 and DEPTH=4, capture 6 records.
  - drop_cnt_o=2.
  - After ready=1, the fifth streamed record has W0[30]=1.
- **Counters:** 3 cycles with stall_i=1 and 2 with flush_i=1.
  - stall_cnt_o=3 and flush_cnt_o=2.
  - Force stall_cnt to 0xFFFF, add one stall: the counter stays 0xFFFF.
- **Reset mid-stream:** assert rst_i after W0 is accepted.
  - valid=0 on the next cycle and all counters read 0.
  - After release, the next record has cycle=0.
- **Event-only mode:** with TRACE_EVENT_ONLY_EN defined, run 4 idle cycles then one with flush_i=1.
  - Exactly one record is produced, with W0[28]=1 and cycle=4.

Source files
------------

// File: rtl/pipe_trace_tx_if.sv
// Trace word stream between pipe_trace_tx (master) and the external trace sink (slave).
interface pipe_trace_tx_if;
  logic [31:0] trace_data_o;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic        trace_last_o;

  modport master (output trace_data_o, trace_valid_o, trace_last_o, input trace_ready_i);
  modport slave  (input trace_data_o, trace_valid_o, trace_last_o, output trace_ready_i);
endinterface

// File: rtl/pipe_trace_tx.sv
// Per-cycle MIPS pipeline trace: packs PC/stall/flush/writeback into 3-word records, buffers and streams them.
// Define TRACE_EVENT_ONLY_EN to capture only cycles with a stall, flush or writeback.
module pipe_trace_tx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      pc_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             wb_en_i,
  input  logic [4:0]       wb_addr_i,
  input  logic [31:0]      wb_data_i,
  pipe_trace_tx_if.master  trace,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } record_t;

  typedef enum logic [1:0] {
    WORD0 = 2'd0,
    WORD1 = 2'd1,
    WORD2 = 2'd2
  } word_idx_e;

  record_t     mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] level;
  logic [21:0] cycle;
  logic        ovf;
  word_idx_e   idx;

  logic    capture_cond;
  logic    capture;
  logic    full;
  logic    empty;
  logic    push;
  logic    drop;
  logic    handshake;
  logic    pop;
  record_t new_rec;
  record_t head;

`ifdef TRACE_EVENT_ONLY_EN
  assign capture_cond = stall_i | flush_i | wb_en_i;
`else
  assign capture_cond = 1'b1;
`endif

  // Fullness is judged on the pre-edge level, so a pop on the same edge never frees room for a capture.
  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == (AW+1)'(DEPTH));
  assign empty     = (level == '0);
  assign capture   = start_i & capture_cond;
  assign push      = capture & ~full;
  assign drop      = capture & full;
  assign handshake = ~empty & trace.trace_ready_i;
  assign pop       = handshake & (idx == WORD2);
  assign head      = mem[rd_ptr[AW-1:0]];

  always_comb begin
    new_rec.w0 = {1'b1, ovf, stall_i, flush_i, wb_en_i, wb_addr_i, cycle};
    new_rec.w1 = pc_i;
    new_rec.w2 = wb_en_i ? wb_data_i : 32'd0;
  end

  // NOTE: every output gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    trace.trace_valid_o = ~empty;
    trace.trace_last_o  = ~empty & (idx == WORD2);
    trace.trace_data_o  = '0;
    if (!empty) begin
      case (idx)
        WORD0:   trace.trace_data_o = head.w0;
        WORD1:   trace.trace_data_o = head.w1;
        default: trace.trace_data_o = head.w2;
      endcase
    end
  end

  // NOTE: record storage is deliberately not reset; the pointers alone say which entries are live.
  // NOTE: state is updated with <= so every register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= new_rec;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cycle       <= '0;
      ovf         <= 1'b0;
      idx         <= WORD0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      if (start_i) cycle <= cycle + 22'd1;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);

      if (drop)      ovf <= 1'b1;
      else if (push) ovf <= 1'b0;

      if (handshake) begin
        case (idx)
          WORD0:   idx <= WORD1;
          WORD1:   idx <= WORD2;
          default: idx <= WORD0;
        endcase
      end

      stall_cnt_o <= sat_inc(stall_cnt_o, start_i & stall_i);
      flush_cnt_o <= sat_inc(flush_cnt_o, start_i & flush_i);
      drop_cnt_o  <= sat_inc(drop_cnt_o, drop);
    end
  end
endmodule

// File: tb/tb_pipe_trace_tx.sv
// Scoreboard bench for pipe_trace_tx: a word-level reference model feeds an expected-word queue
// that an independent monitor drains on every handshake.
module tb_pipe_trace_tx;
  localparam int DEPTH = 4;
  localparam int CNT_W = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  logic             clk     = 1'b0;
  logic             rst     = 1'b1;
  logic             start   = 1'b0;
  logic             stall   = 1'b0;
  logic             flush   = 1'b0;
  logic             wb_en   = 1'b0;
  logic [4:0]       wb_addr = '0;
  logic [31:0]      pc      = '0;
  logic [31:0]      wb_data = '0;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] drop_cnt;

  pipe_trace_tx_if bus ();

  pipe_trace_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .pc_i        (pc),
    .stall_i     (stall),
    .flush_i     (flush),
    .wb_en_i     (wb_en),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .trace       (bus.master),
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt),
    .drop_cnt_o  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  word_t       exp_q[$];
  int          m_stall, m_flush, m_drop;
  int unsigned m_cycle;
  bit          m_ovf;
  bit          m_cap;
  int          m_resident;
  logic [31:0] m_w0;
  logic        mon_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: records are word triples in one queue; a record occupies a slot until its last word leaves.
  initial begin
    m_stall = 0; m_flush = 0; m_drop = 0; m_cycle = 0; m_ovf = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        m_stall = 0; m_flush = 0; m_drop = 0; m_cycle = 0; m_ovf = 0;
      end else if (start) begin
`ifdef TRACE_EVENT_ONLY_EN
        m_cap = stall || flush || wb_en;
`else
        m_cap = 1'b1;
`endif
        if (stall && m_stall < CNT_MAX) m_stall++;
        if (flush && m_flush < CNT_MAX) m_flush++;
        if (m_cap) begin
          m_resident = (exp_q.size() + 2) / 3;
          if (m_resident >= DEPTH) begin
            if (m_drop < CNT_MAX) m_drop++;
            m_ovf = 1'b1;
          end else begin
            m_w0 = {1'b1, m_ovf, stall, flush, wb_en, wb_addr, m_cycle[21:0]};
            exp_q.push_back('{m_w0, 1'b0});
            exp_q.push_back('{pc, 1'b0});
            exp_q.push_back('{(wb_en ? wb_data : 32'd0), 1'b1});
            m_ovf = 1'b0;
          end
        end
        m_cycle = (m_cycle + 1) % (1 << 22);
      end
    end
  end

  // Monitor: compare at negedge, retire the word just after the edge that accepted it.
  initial begin
    forever begin
      @(negedge clk);
      mon_v = bus.trace_valid_o;
      check("valid", 32'(mon_v), 32'(exp_q.size() != 0));
      if (mon_v === 1'b1 && exp_q.size() != 0) begin
        check("data", bus.trace_data_o, exp_q[0].data);
        check("last", 32'(bus.trace_last_o), 32'(exp_q[0].last));
      end else if (mon_v === 1'b0) begin
        check("idle_data", bus.trace_data_o, 32'd0);
        check("idle_last", 32'(bus.trace_last_o), 32'd0);
      end
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      @(posedge clk);
      #1;
      if (mon_v === 1'b1 && bus.trace_ready_i && !rst && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  task automatic drive(input bit st, input bit stl, input bit fl, input bit we, input logic [4:0] wa,
                       input logic [31:0] p, input logic [31:0] wd, input bit rdy);
    @(negedge clk);
    rst     = 1'b0;
    start   = st;
    stall   = stl;
    flush   = fl;
    wb_en   = we;
    wb_addr = wa;
    pc      = p;
    wb_data = wd;
    bus.trace_ready_i = rdy;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; wb_en = 1'b0;
    bus.trace_ready_i = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(bus.trace_valid_o), 32'd0);
    check("rst_last", 32'(bus.trace_last_o), 32'd0);
    check("rst_data", bus.trace_data_o, 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    bus.trace_ready_i = 1'b0;

    // Single record
    do_reset();
    drive(1, 0, 0, 1, 5'd9, 32'h8, 32'h5, 1);
    idle(1); check("single_w0", bus.trace_data_o, 32'h8A40_0000);
    check("single_w0_last", 32'(bus.trace_last_o), 32'd0);
    idle(1); check("single_w1", bus.trace_data_o, 32'h8);
    idle(1); check("single_w2", bus.trace_data_o, 32'h5);
    check("single_w2_last", 32'(bus.trace_last_o), 32'd1);
    idle(1); check("single_done", 32'(bus.trace_valid_o), 32'd0);

    // Backpressure during W1
    drive(1, 0, 0, 1, 5'd3, 32'h8, 32'h5, 1);
    idle(1);
    for (int i = 0; i < 10; i++) begin
      idle(0);
      check("bp_hold_data", bus.trace_data_o, 32'h8);
      check("bp_hold_valid", 32'(bus.trace_valid_o), 32'd1);
    end
    idle(1); check("bp_still_w1", bus.trace_data_o, 32'h8);
    idle(1); check("bp_resume_w2", bus.trace_data_o, 32'h5);

    // Overflow
    do_reset();
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 1, 5'(i), 32'(i * 4), 32'(i + 100), 0);
    idle(0); check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
    repeat (12) idle(1);
    drive(1, 0, 0, 1, 5'd7, 32'h40, 32'h77, 1);
    idle(1); check("ovf_flag_w0", 32'(bus.trace_data_o[30]), 32'd1);

    // Counters and saturation
    do_reset();
    repeat (3) drive(1, 1, 0, 0, 5'd0, 32'h100, 32'd0, 1);
    repeat (2) drive(1, 0, 1, 0, 5'd0, 32'h104, 32'd0, 1);
    idle(1);
    check("stall_cnt_3", 32'(stall_cnt), 32'd3);
    check("flush_cnt_2", 32'(flush_cnt), 32'd2);
    repeat (40) drive(1, 1, 0, 0, 5'd0, 32'h200, 32'd0, 1);
    idle(1); check("stall_cnt_sat", 32'(stall_cnt), 32'(CNT_MAX));
    repeat (20) idle(1);

    // Reset mid-stream
    do_reset();
    drive(1, 1, 1, 1, 5'd4, 32'h300, 32'h33, 1);
    idle(1);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(bus.trace_valid_o), 32'd0);
    check("midrst_stall", 32'(stall_cnt), 32'd0);
    check("midrst_flush", 32'(flush_cnt), 32'd0);
    drive(1, 0, 0, 1, 5'd2, 32'h400, 32'h44, 1);
    idle(1); check("midrst_cycle0", bus.trace_data_o & 32'h003F_FFFF, 32'd0);
    repeat (4) idle(1);

`ifdef TRACE_EVENT_ONLY_EN
    // Event-only: idle cycles advance the timestamp but produce no record
    do_reset();
    repeat (4) drive(1, 0, 0, 0, 5'd0, 32'h500, 32'd0, 1);
    drive(1, 0, 1, 0, 5'd0, 32'h514, 32'd0, 1);
    idle(1);
    check("ev_flush_bit", 32'(bus.trace_data_o[28]), 32'd1);
    check("ev_cycle", bus.trace_data_o & 32'h003F_FFFF, 32'd4);
    repeat (3) idle(1);
    check("ev_one_record", 32'(bus.trace_valid_o), 32'd0);
`endif

    // Randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 2) == 0, 5'($urandom), $urandom, $urandom, $urandom_range(0, 4) < 3);
    end
    repeat (40) idle(1);
    check("drained", 32'(bus.trace_valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
